// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED message writer: message kinds,
// ASCII codes, FSM encoding, the fixed label ROM and rise-priority helper.
package oled_pkg;

  // The numeric value of a kind is both its OLED row and its priority (higher wins).
  typedef enum logic [1:0] {
    KIND_PRICE = 2'd0,
    KIND_COIN  = 2'd1,
    KIND_TOTAL = 2'd2,
    KIND_DISP  = 2'd3
  } msg_kind_e;

  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_DOT    = 8'h2E;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  localparam int LABEL_LEN   = 16;
  localparam int POS_DOLLARS = 7;
  localparam int POS_TENS    = 9;
  localparam int POS_UNITS   = 10;

  // Label ROM; digit positions hold '0' placeholders that the top overrides.
  function automatic logic [7:0] label_char(msg_kind_e kind, int unsigned idx);
    logic [8*LABEL_LEN-1:0] text;
    case (kind)
      KIND_PRICE: text = "PRICE $0.00     ";
      KIND_COIN:  text = "COIN  $0.00     ";
      KIND_TOTAL: text = "TOTAL $0.00     ";
      default:    text = "*DISPENSE*      ";
    endcase
    if (idx >= LABEL_LEN) return ASCII_SPACE;
    return text[8*(LABEL_LEN-1-idx) +: 8];
  endfunction

  // Highest-priority kind in a rise vector indexed by msg_kind_e.
  function automatic msg_kind_e top_kind(logic [3:0] rise);
    if (rise[3]) return KIND_DISP;
    if (rise[2]) return KIND_TOTAL;
    if (rise[1]) return KIND_COIN;
    return KIND_PRICE;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per cycle.
// done is high in the cycle of the final shift; bcd is valid from the next cycle.
module bin2bcd_seq #(
  parameter int VAL_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [11:0]      bcd
);

  localparam int CNT_W = $clog2(VAL_W) + 1;

  logic [VAL_W-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [11:0]      adj;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    adj = bcd;
    for (int d = 0; d < 3; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  assign done = busy && (cnt == CNT_W'(VAL_W - 1));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      shreg <= '0;
      bcd   <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      shreg <= bin;
      bcd   <= '0;
    end else if (busy) begin
      bcd   <= {adj[10:0], shreg[VAL_W-1]};
      shreg <= shreg << 1;
      cnt   <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/oled_msg_writer.sv
// Serializes fixed 16-character OLED messages (with a $D.CC value field) to the
// character driver over valid/ready, queueing one pending message.
module oled_msg_writer
  import oled_pkg::*;
#(
  parameter int VAL_W   = 9,
  parameter int MSG_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_reg,
  input  logic             ld_price,
  input  logic             ld_cents,
  input  logic             ld_coins,
  input  logic             ld_disp,
  input  logic [VAL_W-1:0] price,
  input  logic [VAL_W-1:0] cents_in,
  input  logic [VAL_W-1:0] total,
  input  logic             disp_rdy,
  output logic             disp_wr,
  output logic [7:0]       disp_char,
  output logic [1:0]       disp_row,
  output logic [3:0]       disp_col,
  output logic             char_done
);

  localparam int IDX_W = $clog2(MSG_LEN);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  msg_kind_e        cur_kind;
  logic             done_q;
  logic             pend_vld;
  msg_kind_e        pend_kind;
  logic [3:0]       ld_q;

  logic [3:0]       ld_now, rise, rest;
  logic             any_rise;
  msg_kind_e        hi_kind, hi2_kind;
  logic             last_xfer;
  logic             start_go;
  msg_kind_e        start_kind;
  logic             pend_nxt_vld;
  msg_kind_e        pend_nxt_kind;
  logic             conv_start, conv_busy, conv_done;
  logic [VAL_W-1:0] conv_bin;
  logic [11:0]      bcd;

  // Rise vector is indexed by msg_kind_e; rises during clr_reg are dropped.
  assign ld_now   = {ld_disp, ld_coins, ld_cents, ld_price};
  assign rise     = ld_now & ~ld_q & {4{~clr_reg}};
  assign any_rise = |rise;
  assign hi_kind  = top_kind(rise);
  assign rest     = rise & ~(4'b0001 << hi_kind);
  assign hi2_kind = top_kind(rest);

  assign last_xfer = (state == ST_SEND) && disp_rdy && (idx == IDX_W'(MSG_LEN - 1));

  // Start selection and next pending-slot contents.
  always_comb begin
    start_go      = 1'b0;
    start_kind    = cur_kind;
    pend_nxt_vld  = pend_vld;
    pend_nxt_kind = pend_kind;
    if (clr_reg) begin
      pend_nxt_vld = 1'b0;
    end else if (state == ST_IDLE) begin
      if (any_rise) begin
        start_go      = 1'b1;
        start_kind    = hi_kind;
        pend_nxt_vld  = |rest;
        pend_nxt_kind = hi2_kind;
      end
    end else if (last_xfer && pend_vld) begin
      start_go      = 1'b1;
      start_kind    = pend_kind;
      pend_nxt_vld  = any_rise;
      pend_nxt_kind = hi_kind;
    end else if (any_rise && (!pend_vld || hi_kind > pend_kind)) begin
      pend_nxt_vld  = 1'b1;
      pend_nxt_kind = hi_kind;
    end
  end

  assign conv_start = start_go && (start_kind != KIND_DISP);

  always_comb begin
    case (start_kind)
      KIND_PRICE: conv_bin = price;
      KIND_COIN:  conv_bin = cents_in;
      default:    conv_bin = total;
    endcase
  end

  bin2bcd_seq #(.VAL_W(VAL_W)) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cur_kind  <= KIND_PRICE;
      done_q    <= 1'b0;
      pend_vld  <= 1'b0;
      pend_kind <= KIND_PRICE;
      ld_q      <= 4'b1111;
    end else begin
      ld_q      <= ld_now;
      pend_vld  <= pend_nxt_vld;
      pend_kind <= pend_nxt_kind;
      if (clr_reg) begin
        state  <= ST_IDLE;
        done_q <= 1'b0;
      end else if (start_go) begin
        cur_kind <= start_kind;
        idx      <= '0;
        done_q   <= 1'b0;
        state    <= (start_kind == KIND_DISP) ? ST_SEND : ST_CONV;
      end else if (state == ST_CONV) begin
        if (conv_busy && conv_done) begin
          state <= ST_SEND;
          idx   <= '0;
        end
      end else if (state == ST_SEND && disp_rdy) begin
        if (last_xfer) begin
          state  <= ST_IDLE;
          done_q <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  // Character mux: label ROM, with BCD digits at the value positions.
  always_comb begin
    disp_char = ASCII_SPACE;
    if (state == ST_SEND) begin
      disp_char = label_char(cur_kind, 32'(idx));
      if (cur_kind != KIND_DISP) begin
        if (int'(idx) == POS_DOLLARS) disp_char = ASCII_ZERO + {4'd0, bcd[11:8]};
        if (int'(idx) == POS_TENS)    disp_char = ASCII_ZERO + {4'd0, bcd[7:4]};
        if (int'(idx) == POS_UNITS)   disp_char = ASCII_ZERO + {4'd0, bcd[3:0]};
      end
    end
  end

  assign disp_wr   = (state == ST_SEND);
  assign disp_row  = cur_kind;
  assign disp_col  = 4'(idx);
  assign char_done = done_q & ~any_rise & ~clr_reg;

endmodule

// File: tb/tb_oled_msg_writer.sv
// Directed bench for oled_msg_writer: message text, timing, handshake
// stability, pending-slot ordering, done masking, clear and reset.
module tb_oled_msg_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_reg, ld_price, ld_cents, ld_coins, ld_disp;
  logic [8:0] price, cents_in, total;
  logic       disp_rdy;
  logic       disp_wr;
  logic [7:0] disp_char;
  logic [1:0] disp_row;
  logic [3:0] disp_col;
  logic       char_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] cap_char [64];
  logic [1:0] cap_row  [64];
  logic [3:0] cap_col  [64];
  int         cap_cyc  [64];
  int         n_cap, first_wr, done_cyc, stab_err;

  always #5 clk = ~clk;

  oled_msg_writer dut (
    .clk       (clk),
    .rst       (rst),
    .clr_reg   (clr_reg),
    .ld_price  (ld_price),
    .ld_cents  (ld_cents),
    .ld_coins  (ld_coins),
    .ld_disp   (ld_disp),
    .price     (price),
    .cents_in  (cents_in),
    .total     (total),
    .disp_rdy  (disp_rdy),
    .disp_wr   (disp_wr),
    .disp_char (disp_char),
    .disp_row  (disp_row),
    .disp_col  (disp_col),
    .char_done (char_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs up to max_cycles after the rise cycle (cycle 1 = rise+1), ready high
  // every period-th cycle, recording transfers until char_done is seen.
  task automatic capture(input int period, input int max_cycles);
    logic       held;
    logic [7:0] pc;
    logic [1:0] pr;
    logic [3:0] pcol;
    n_cap = 0; first_wr = -1; done_cyc = -1; stab_err = 0;
    held = 1'b0; pc = '0; pr = '0; pcol = '0;
    for (int c = 1; c <= max_cycles; c++) begin
      step();
      disp_rdy = (c % period) == 0;
      @(negedge clk);
      if (held && (disp_wr !== 1'b1 || disp_char !== pc || disp_row !== pr || disp_col !== pcol))
        stab_err++;
      if (disp_wr === 1'b1 && first_wr < 0) first_wr = c;
      if (disp_wr === 1'b1 && disp_rdy && n_cap < 64) begin
        cap_char[n_cap] = disp_char;
        cap_row[n_cap]  = disp_row;
        cap_col[n_cap]  = disp_col;
        cap_cyc[n_cap]  = c;
        n_cap++;
      end
      held = (disp_wr === 1'b1) && !disp_rdy;
      pc = disp_char; pr = disp_row; pcol = disp_col;
      if (char_done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    disp_rdy = 1'b1;
  endtask

  function automatic string cap_str(int from, int cnt);
    string s = "";
    for (int i = from; i < from + cnt && i < n_cap; i++) s = $sformatf("%s%c", s, cap_char[i]);
    return s;
  endfunction

  function automatic int bad_pos(int from, int cnt, logic [1:0] row);
    int bad = 0;
    for (int i = 0; i < cnt; i++)
      if (from + i >= n_cap || cap_row[from+i] !== row || cap_col[from+i] !== 4'(i)) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    rst = 1'b0; clr_reg = 1'b0; disp_rdy = 1'b1;
    ld_price = 1'b0; ld_cents = 1'b0; ld_coins = 1'b0; ld_disp = 1'b0;
    price = '0; cents_in = '0; total = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (disp_wr !== 1'b0)     begin errors++; $display("FAIL reset_wr got %b exp 0", disp_wr); end
    checks++; if (disp_char !== 8'h20)  begin errors++; $display("FAIL reset_char got %h exp 20", disp_char); end
    checks++; if (disp_row !== 2'd0)    begin errors++; $display("FAIL reset_row got %0d exp 0", disp_row); end
    checks++; if (disp_col !== 4'd0)    begin errors++; $display("FAIL reset_col got %0d exp 0", disp_col); end
    checks++; if (char_done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b exp 0", char_done); end
    step();
    rst = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_price();
    string exp_s = "PRICE $1.50     ";
    step();
    price = 9'd150; ld_price = 1'b1;
    capture(1, 40);
    checks++; if (cap_str(0, 16) != exp_s) begin errors++; $display("FAIL price_text got \"%s\" exp \"%s\"", cap_str(0, 16), exp_s); end
    checks++; if (bad_pos(0, 16, 2'd0) != 0) begin errors++; $display("FAIL price_pos got %0d bad exp 0", bad_pos(0, 16, 2'd0)); end
    checks++; if (first_wr != 10) begin errors++; $display("FAIL price_first_wr got %0d exp 10", first_wr); end
    checks++; if (done_cyc != 26) begin errors++; $display("FAIL price_done got %0d exp 26", done_cyc); end
    ld_price = 1'b0;
  endtask

  task automatic test_coin_throttled();
    string exp_s = "COIN  $0.25     ";
    step();
    cents_in = 9'd25; ld_cents = 1'b1;
    capture(3, 90);
    checks++; if (cap_str(0, 16) != exp_s) begin errors++; $display("FAIL coin_text got \"%s\" exp \"%s\"", cap_str(0, 16), exp_s); end
    checks++; if (n_cap != 16 || bad_pos(0, 16, 2'd1) != 0) begin errors++; $display("FAIL coin_count got %0d xfers exp 16 in order", n_cap); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL coin_stable got %0d changes exp 0", stab_err); end
    checks++; if (first_wr != 10) begin errors++; $display("FAIL coin_first_wr got %0d exp 10", first_wr); end
    ld_cents = 1'b0;
  endtask

  task automatic test_back_to_back();
    string exp_d = "*DISPENSE*      ";
    string exp_t = "TOTAL $3.07     ";
    step();
    total = 9'd307; ld_coins = 1'b1; ld_disp = 1'b1;
    capture(1, 70);
    checks++; if (cap_str(0, 16) != exp_d || bad_pos(0, 16, 2'd3) != 0) begin errors++; $display("FAIL b2b_disp got \"%s\" exp \"%s\" row 3", cap_str(0, 16), exp_d); end
    checks++; if (cap_str(16, 16) != exp_t || bad_pos(16, 16, 2'd2) != 0) begin errors++; $display("FAIL b2b_total got \"%s\" exp \"%s\" row 2", cap_str(16, 16), exp_t); end
    checks++; if (n_cap < 17 || cap_cyc[16] != 26) begin errors++; $display("FAIL b2b_second_start got %0d exp 26", n_cap < 17 ? -1 : cap_cyc[16]); end
    checks++; if (done_cyc != 42) begin errors++; $display("FAIL b2b_done got %0d exp 42", done_cyc); end
  endtask

  task automatic test_done_mask();
    string exp_s = "TOTAL $5.11     ";
    step();
    ld_coins = 1'b0; ld_disp = 1'b0; total = 9'd511;
    @(negedge clk);
    checks++; if (char_done !== 1'b1) begin errors++; $display("FAIL mask_held got %b exp 1", char_done); end
    step();
    ld_coins = 1'b1;
    @(negedge clk);
    checks++; if (char_done !== 1'b0) begin errors++; $display("FAIL mask_same_cycle got %b exp 0", char_done); end
    capture(1, 40);
    checks++; if (cap_str(0, 16) != exp_s) begin errors++; $display("FAIL mask_text got \"%s\" exp \"%s\"", cap_str(0, 16), exp_s); end
    checks++; if (done_cyc != 26) begin errors++; $display("FAIL mask_done got %0d exp 26", done_cyc); end
    ld_coins = 1'b0;
  endtask

  task automatic test_clr();
    bit found = 0;
    int wr_cnt = 0, done_cnt = 0;
    step();
    price = 9'd99; ld_price = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      @(negedge clk);
      if (disp_wr === 1'b1 && disp_col === 4'd7) begin found = 1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL clr_reach_char7 got timeout exp col 7"); end
    clr_reg = 1'b1;
    #1;
    checks++; if (char_done !== 1'b0) begin errors++; $display("FAIL clr_done got %b exp 0", char_done); end
    step();
    clr_reg = 1'b0;
    @(negedge clk);
    checks++; if (disp_wr !== 1'b0) begin errors++; $display("FAIL clr_wr got %b exp 0", disp_wr); end
    for (int c = 0; c < 20; c++) begin
      step();
      @(negedge clk);
      if (disp_wr === 1'b1) wr_cnt++;
      if (char_done === 1'b1) done_cnt++;
    end
    checks++; if (wr_cnt != 0 || done_cnt != 0) begin errors++; $display("FAIL clr_quiet got wr %0d done %0d exp 0 0", wr_cnt, done_cnt); end
    ld_price = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    bit found = 0;
    int wr_cnt = 0, done_cnt = 0;
    step();
    ld_disp = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      @(negedge clk);
      if (disp_wr === 1'b1 && disp_col === 4'd3) begin found = 1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach got timeout exp col 3"); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (disp_wr !== 1'b0)    begin errors++; $display("FAIL rstmid_wr got %b exp 0", disp_wr); end
    checks++; if (disp_char !== 8'h20) begin errors++; $display("FAIL rstmid_char got %h exp 20", disp_char); end
    checks++; if (disp_row !== 2'd0 || disp_col !== 4'd0) begin errors++; $display("FAIL rstmid_rowcol got %0d/%0d exp 0/0", disp_row, disp_col); end
    checks++; if (char_done !== 1'b0)  begin errors++; $display("FAIL rstmid_done got %b exp 0", char_done); end
    step();
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      @(negedge clk);
      if (disp_wr === 1'b1) wr_cnt++;
      if (char_done === 1'b1) done_cnt++;
    end
    checks++; if (wr_cnt != 0 || done_cnt != 0) begin errors++; $display("FAIL rstmid_no_msg got wr %0d done %0d exp 0 0", wr_cnt, done_cnt); end
    ld_disp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_price();
    test_coin_throttled();
    test_back_to_back();
    test_done_mask();
    test_clr();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
